// File: rtl/jtag_bus_master_if.sv
// -----------------------------------------------------------------------------
// jtag_bus_master_if
//   Single-master register bus between jtag_bus_master and an on-chip slave.
//   One transaction at a time: bus_req is held with bus_we/bus_addr/bus_wdata
//   stable until the slave returns a single-cycle bus_ack.
//
//   Signals
//     bus_req    master -> slave  transaction request
//     bus_we     master -> slave  1 = write, 0 = read
//     bus_addr   master -> slave  register address (ADDR_W)
//     bus_wdata  master -> slave  write data (DATA_W)
//     bus_ack    slave  -> master single-cycle completion strobe
//     bus_rdata  slave  -> master read data, valid with bus_ack on reads
// -----------------------------------------------------------------------------
interface jtag_bus_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/jtag_bus_master.sv
// -----------------------------------------------------------------------------
// jtag_bus_master
//   Turns command words written by a JTAG host into register-bus transactions
//   in the clk domain. The host flips cmd_tgl to post a new command; this block
//   synchronises the toggle, runs one bus transaction (with an ack timeout) and
//   reports completion by copying the toggle back into done_tgl together with
//   busy, err and the read data.
//
//   Ports
//     clk       in   system clock, all logic on the rising edge
//     rst       in   synchronous active-high reset
//     jtag_cmd  in   {cmd_tgl, we, addr[ADDR_W], wdata[DATA_W]} (TCK domain)
//     jtag_rsp  out  {done_tgl, busy, err, rdata[DATA_W]}
//     bus       master modport of jtag_bus_master_if
// -----------------------------------------------------------------------------
module jtag_bus_master #(
  parameter  int ADDR_W  = 8,
  parameter  int DATA_W  = 16,
  parameter  int TIMEOUT = 255,
  localparam int CMD_W   = ADDR_W + DATA_W + 2,
  localparam int RSP_W   = DATA_W + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CMD_W-1:0]     jtag_cmd,
  output logic [RSP_W-1:0]     jtag_rsp,
  jtag_bus_master_if.master    bus
);

  // Counter only needs to reach TIMEOUT-1 (the last REQ cycle).
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic               tgl_s1;
  logic               tgl_s2;
  logic               last_tgl;
  logic [CNT_W-1:0]   cnt;

  logic               capture;
  logic               ack_hit;
  logic               tmo_hit;

  logic               we_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic               done_tgl;
  logic               err;
  logic [DATA_W-1:0]  rdata;

  // ---- toggle synchroniser: s1 then s2 ----
  // Only the toggle crosses through flops; the remaining command bits have
  // been stable for at least two clk cycles by the time s2 shows the change,
  // so they are sampled directly at capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgl_s1 <= 1'b0;
      tgl_s2 <= 1'b0;
    end else begin
      tgl_s1 <= jtag_cmd[CMD_W-1];
      tgl_s2 <= tgl_s1;
    end
  end

  // ---- sequencer state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle decisions. Ack is checked before the timeout so a
  // coincident ack completes the transaction successfully.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    ack_hit   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (tgl_s2 != last_tgl) begin
          capture   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.bus_ack) begin
          ack_hit   = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- command capture, bus registers and response ----
  // done_tgl is updated on leaving DONE, one cycle after rdata/err, so a JTAG
  // capture that sees the new done_tgl always sees settled data.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_tgl <= 1'b0;
      cnt      <= '0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      done_tgl <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
    end else begin
      if (capture) begin
        last_tgl <= tgl_s2;
        we_r     <= jtag_cmd[CMD_W-2];
        addr_r   <= jtag_cmd[ADDR_W+DATA_W-1:DATA_W];
        wdata_r  <= jtag_cmd[DATA_W-1:0];
        cnt      <= '0;
      end else if (state == REQ) begin
        cnt <= cnt + 1'b1;
      end

      if (ack_hit) begin
        err <= 1'b0;
        if (!we_r) begin
          rdata <= bus.bus_rdata;
        end
      end else if (tmo_hit) begin
        err <= 1'b1;
      end

      if (state == DONE) begin
        done_tgl <= last_tgl;
      end
    end
  end

  assign bus.bus_req   = (state == REQ);
  assign bus.bus_we    = we_r;
  assign bus.bus_addr  = addr_r;
  assign bus.bus_wdata = wdata_r;

  assign jtag_rsp = {done_tgl, (state != IDLE), err, rdata};

endmodule

// File: tb/tb_jtag_bus_master.sv
module tb_jtag_bus_master;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 4;
  localparam int CMD_W   = ADDR_W + DATA_W + 2;
  localparam int RSP_W   = DATA_W + 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [CMD_W-1:0] jtag_cmd;
  logic [RSP_W-1:0] jtag_rsp;

  jtag_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  jtag_bus_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .jtag_cmd(jtag_cmd),
    .jtag_rsp(jtag_rsp),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int          len;
  } bus_exp_t;

  typedef struct {
    logic        tgl;
    logic        err;
    logic [15:0] rdata;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];

  int          ack_at    = 0;     // REQ cycle on which the slave acks, 0 = never
  logic [15:0] slv_rdata = 16'h0;
  bit          mon_en    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input logic we, input logic [7:0] addr, input logic [15:0] wdata,
                         input int len);
    bus_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.len = len;
    bus_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic tgl, input logic err, input logic [15:0] rdata);
    rsp_exp_t e;
    e.tgl = tgl; e.err = err; e.rdata = rdata;
    rsp_q.push_back(e);
  endtask

  // Bus slave: acks on the ack_at-th consecutive REQ cycle, garbage rdata otherwise.
  initial begin
    int slv_cnt;
    slv_cnt       = 0;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.bus_req === 1'b1) begin
        slv_cnt++;
        bus.bus_ack   = (ack_at != 0) && (slv_cnt == ack_at);
        bus.bus_rdata = bus.bus_ack ? slv_rdata : 16'hDEAD;
      end else begin
        slv_cnt       = 0;
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 16'hDEAD;
      end
    end
  end

  // Bus monitor: one scoreboard entry per bus_req pulse.
  initial begin
    bit          in_req;
    bit          stable;
    logic        cur_we;
    logic [7:0]  cur_addr;
    logic [15:0] cur_wdata;
    int          cur_len;
    bus_exp_t    e;
    in_req = 1'b0; stable = 1'b1; cur_len = 0;
    cur_we = 1'b0; cur_addr = '0; cur_wdata = '0;
    forever begin
      @(negedge clk);
      if (bus.bus_req === 1'b1) begin
        if (!in_req) begin
          in_req    = 1'b1;
          stable    = 1'b1;
          cur_len   = 1;
          cur_we    = bus.bus_we;
          cur_addr  = bus.bus_addr;
          cur_wdata = bus.bus_wdata;
        end else begin
          cur_len++;
          if (bus.bus_we !== cur_we || bus.bus_addr !== cur_addr ||
              bus.bus_wdata !== cur_wdata)
            stable = 1'b0;
        end
      end else if (in_req) begin
        in_req = 1'b0;
        if (bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_unexpected: transaction addr 0x%0h len %0d with none pending",
                   cur_addr, cur_len);
        end else begin
          e = bus_q.pop_front();
          chk("bus_we",     cur_we,    e.we);
          chk("bus_addr",   cur_addr,  e.addr);
          chk("bus_wdata",  cur_wdata, e.wdata);
          chk("bus_req_len", cur_len,  e.len);
          chk("bus_stable", stable,    1'b1);
        end
      end
    end
  end

  // Response monitor: each done_tgl change pops one expected response.
  initial begin
    logic        prev_done;
    logic        prev_err;
    logic [15:0] prev_rdata;
    rsp_exp_t    e;
    prev_done = 1'b0; prev_err = 1'b0; prev_rdata = '0;
    forever begin
      @(negedge clk);
      if (mon_en && jtag_rsp[RSP_W-1] !== prev_done) begin
        if (rsp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected: done_tgl changed to %0b with none pending",
                   jtag_rsp[RSP_W-1]);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_done_tgl",   jtag_rsp[RSP_W-1],  e.tgl);
          chk("rsp_busy",       jtag_rsp[RSP_W-2],  1'b0);
          chk("rsp_err",        jtag_rsp[RSP_W-3],  e.err);
          chk("rsp_rdata",      jtag_rsp[15:0],     e.rdata);
          chk("rsp_err_early",  prev_err,           e.err);
          chk("rsp_rdata_early", prev_rdata,        e.rdata);
        end
      end
      prev_done  = jtag_rsp[RSP_W-1];
      prev_err   = jtag_rsp[RSP_W-3];
      prev_rdata = jtag_rsp[15:0];
    end
  end

  task automatic drive_cmd(input logic tgl, input logic we, input logic [7:0] addr,
                           input logic [15:0] wdata);
    @(posedge clk);
    #1 jtag_cmd = {tgl, we, addr, wdata};
  endtask

  // Waits for done_tgl == tgl with busy low; edge count starts at the first
  // edge after the command was driven.
  task automatic wait_done(input logic tgl, input int exp_edges, input string name);
    int edges;
    bit seen;
    edges = 0;
    seen  = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (jtag_rsp[RSP_W-1] === tgl && jtag_rsp[RSP_W-2] === 1'b0) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_wait: done_tgl=%0b never reached %0b within 60 cycles",
               name, jtag_rsp[RSP_W-1], tgl);
    end else if (exp_edges != 0) begin
      chk({name, "_edges"}, edges, exp_edges);
    end
  endtask

  task automatic wait_req(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.bus_req === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_req: bus_req=%0b never rose within 20 cycles", name, bus.bus_req);
    end
  endtask

  task automatic run_cmd(input logic tgl, input logic we, input logic [7:0] addr,
                         input logic [15:0] wdata, input int ack_i, input logic [15:0] rd_i,
                         input int len, input logic err, input logic [15:0] rdata,
                         input string name);
    ack_at    = ack_i;
    slv_rdata = rd_i;
    exp_bus(we, addr, wdata, len);
    exp_rsp(tgl, err, rdata);
    drive_cmd(tgl, we, addr, wdata);
    wait_done(tgl, 4 + len, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    jtag_cmd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp",       jtag_rsp,      '0);
    chk("rst_bus_req",   bus.bus_req,   1'b0);
    chk("rst_bus_we",    bus.bus_we,    1'b0);
    chk("rst_bus_addr",  bus.bus_addr,  8'h00);
    chk("rst_bus_wdata", bus.bus_wdata, 16'h0000);
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Write, ack on 3rd REQ cycle; rdata stays at reset value.
    run_cmd(1'b1, 1'b1, 8'h12, 16'hBEEF, 3, 16'h1111, 3, 1'b0, 16'h0000, "write");
    // Read, ack in first REQ cycle: best-case turnaround.
    run_cmd(1'b0, 1'b0, 8'h34, 16'h0000, 1, 16'hA5C3, 1, 1'b0, 16'hA5C3, "read");
    // No ack: TIMEOUT REQ cycles, err set, rdata kept.
    run_cmd(1'b1, 1'b0, 8'h56, 16'h0000, 0, 16'h2222, 4, 1'b1, 16'hA5C3, "timeout");
    // Successful read clears err.
    run_cmd(1'b0, 1'b0, 8'h78, 16'h0000, 1, 16'h1234, 1, 1'b0, 16'h1234, "read_after_tmo");
    // Ack in the last allowed cycle beats the timeout.
    run_cmd(1'b1, 1'b0, 8'h9A, 16'h0000, 4, 16'h5678, 4, 1'b0, 16'h5678, "ack_at_tmo");

    // Toggle flipped twice while busy: no second transaction.
    ack_at    = 3;
    slv_rdata = 16'h9999;
    exp_bus(1'b1, 8'hAB, 16'h0F0F, 3);
    exp_rsp(1'b0, 1'b0, 16'h5678);
    drive_cmd(1'b0, 1'b1, 8'hAB, 16'h0F0F);
    wait_req("dflip");
    @(posedge clk);
    #1 jtag_cmd[CMD_W-1] = 1'b1;
    @(posedge clk);
    #1 jtag_cmd[CMD_W-1] = 1'b0;
    wait_done(1'b0, 0, "dflip");
    repeat (8) @(posedge clk);

    // Toggle flipped once while busy: one follow-on with the latest word.
    ack_at    = 3;
    slv_rdata = 16'h4321;
    exp_bus(1'b0, 8'hCD, 16'h0000, 3);
    exp_bus(1'b1, 8'hEF, 16'h7777, 3);
    exp_rsp(1'b1, 1'b0, 16'h4321);
    exp_rsp(1'b0, 1'b0, 16'h4321);
    drive_cmd(1'b1, 1'b0, 8'hCD, 16'h0000);
    wait_req("sflip");
    @(posedge clk);
    #1 jtag_cmd = {1'b0, 1'b1, 8'hEF, 16'h7777};
    wait_done(1'b1, 0, "sflip_first");
    wait_done(1'b0, 0, "sflip_second");

    // Reset during REQ with cmd_tgl=1: abandoned, then re-executed.
    ack_at = 0;
    exp_bus(1'b0, 8'h11, 16'h0000, 2);
    drive_cmd(1'b1, 1'b0, 8'h11, 16'h0000);
    wait_req("rst_mid");
    @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_bus_req", bus.bus_req, 1'b0);
    chk("rst_mid_rsp",     jtag_rsp,    '0);
    @(posedge clk);
    #1 rst = 1'b0;
    ack_at    = 1;
    slv_rdata = 16'h2468;
    exp_bus(1'b0, 8'h11, 16'h0000, 1);
    exp_rsp(1'b1, 1'b0, 16'h2468);
    mon_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rst_reexec_req_edge%0d", i), bus.bus_req, (i == 3));
    end
    wait_done(1'b1, 0, "rst_reexec");

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("bus_q_drained", bus_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
